controle_divisor: RTL and testbench



---
 rtl/controle_divisor.sv | 182 ++++++++++++++++++
 tb/tb_controle_divisor.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/controle_divisor.sv
// controle_divisor
// Sequential 4-bit unsigned restoring-division controller. Captures A and B on
// an accepted Start, produces one quotient bit per clock, and holds Q/R plus
// the captured operands for the seven-segment output stage, whose active-low
// Strobe is asserted only while a finished result is held.
//
// Ports:
//   Clock   - system clock, rising edge
//   Reset   - synchronous, active-high reset
//   Start   - level-sensitive division request (honoured in IDLE and DONE)
//   A, B    - dividend / divisor, captured on accepted Start
//   Q, R    - quotient / remainder, updated only on entry to DONE
//   Aout    - captured dividend
//   Bout    - captured divisor
//   Strobe  - 0 while result is valid (DONE), 1 otherwise
//   Busy    - high in CALC
//   Done    - high in DONE
//   DivZero - high in DONE when the captured divisor was zero
module controle_divisor (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [3:0] Q,
  output logic [3:0] R,
  output logic [3:0] Aout,
  output logic [3:0] Bout,
  output logic       Strobe,
  output logic       Busy,
  output logic       Done,
  output logic       DivZero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] d_q, d_d;     // dividend shift register, becomes quotient
  logic [3:0] p_q, p_d;     // partial remainder
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] q_q, q_d;
  logic [3:0] r_q, r_d;
  logic       dz_q, dz_d;

  // One restoring step, computed from the current D/P/Bout.
  logic [4:0] trial_s;
  logic [4:0] diff_s;
  logic       ge_s;
  logic [3:0] step_p_s;
  logic [3:0] step_d_s;

  // Restoring-division step datapath.
  always_comb begin
    trial_s  = {p_q, d_q[3]};
    diff_s   = trial_s - {1'b0, b_q};
    ge_s     = (trial_s >= {1'b0, b_q});
    step_d_s = {d_q[2:0], ge_s};
    if (ge_s) begin
      step_p_s = diff_s[3:0];
    end else begin
      step_p_s = trial_s[3:0];
    end
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) state_d = ST_CALC;
        else       state_d = ST_IDLE;
      end
      ST_CALC: begin
        // Zero divisor finishes immediately; otherwise the cnt==0 step is last.
        if ((b_q == 4'd0) || (cnt_q == 2'd0)) state_d = ST_DONE;
        else                                  state_d = ST_CALC;
      end
      ST_DONE: begin
        if (Start) state_d = ST_CALC;
        else       state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state: operand capture, iteration, result load.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    d_d   = d_q;
    p_d   = p_q;
    cnt_d = cnt_q;
    q_d   = q_q;
    r_d   = r_q;
    dz_d  = dz_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          a_d   = A;
          b_d   = B;
          d_d   = A;
          p_d   = 4'd0;
          cnt_d = 2'd3;
        end else begin
          a_d = a_q;
        end
      end
      ST_CALC: begin
        if (b_q == 4'd0) begin
          q_d  = 4'hF;
          r_d  = a_q;
          dz_d = 1'b1;
        end else begin
          d_d = step_d_s;
          p_d = step_p_s;
          if (cnt_q == 2'd0) begin
            q_d  = step_d_s;
            r_d  = step_p_s;
            dz_d = 1'b0;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
      end
      default: begin
        a_d = a_q;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      a_q   <= 4'd0;
      b_q   <= 4'd0;
      d_q   <= 4'd0;
      p_q   <= 4'd0;
      cnt_q <= 2'd0;
      q_q   <= 4'd0;
      r_q   <= 4'd0;
      dz_q  <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      d_q   <= d_d;
      p_q   <= p_d;
      cnt_q <= cnt_d;
      q_q   <= q_d;
      r_q   <= r_d;
      dz_q  <= dz_d;
    end
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    Busy    = (state_q == ST_CALC);
    Done    = (state_q == ST_DONE);
    Strobe  = ~(state_q == ST_DONE);
    // dz_q keeps its old value through a later CALC, so qualify it with DONE.
    DivZero = dz_q & (state_q == ST_DONE);
    Q       = q_q;
    R       = r_q;
    Aout    = a_q;
    Bout    = b_q;
  end

endmodule

// File: tb/tb_controle_divisor.sv
module tb_controle_divisor;

  logic       Clock;
  logic       Reset;
  logic       Start;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] Q;
  logic [3:0] R;
  logic [3:0] Aout;
  logic [3:0] Bout;
  logic       Strobe;
  logic       Busy;
  logic       Done;
  logic       DivZero;

  int err_cnt;
  int chk_cnt;

  controle_divisor dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Start  (Start),
    .A      (A),
    .B      (B),
    .Q      (Q),
    .R      (R),
    .Aout   (Aout),
    .Bout   (Bout),
    .Strobe (Strobe),
    .Busy   (Busy),
    .Done   (Done),
    .DivZero(DivZero)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Wait for Done with a cycle budget; returns cycles spent after the start edge.
  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (!Done && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_done_seen"}, {31'd0, Done}, 32'd1);
  endtask

  // Start a division, wait for completion and check every result output.
  task automatic run_div(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] eq, input logic [3:0] er,
                         input logic dz, input int lat);
    int n;
    A = a; B = b; Start = 1'b1;
    tick();
    Start = 1'b0;
    check_eq({tag, "_busy"}, {31'd0, Busy}, 32'd1);
    check_eq({tag, "_strobe_calc"}, {31'd0, Strobe}, 32'd1);
    wait_done(tag, n);
    check_eq({tag, "_lat"}, n, lat);
    check_eq({tag, "_q"}, {28'd0, Q}, {28'd0, eq});
    check_eq({tag, "_r"}, {28'd0, R}, {28'd0, er});
    check_eq({tag, "_aout"}, {28'd0, Aout}, {28'd0, a});
    check_eq({tag, "_bout"}, {28'd0, Bout}, {28'd0, b});
    check_eq({tag, "_strobe"}, {31'd0, Strobe}, 32'd0);
    check_eq({tag, "_dz"}, {31'd0, DivZero}, {31'd0, dz});
    check_eq({tag, "_busy_done"}, {31'd0, Busy}, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_q"}, {28'd0, Q}, 32'd0);
    check_eq({tag, "_r"}, {28'd0, R}, 32'd0);
    check_eq({tag, "_aout"}, {28'd0, Aout}, 32'd0);
    check_eq({tag, "_bout"}, {28'd0, Bout}, 32'd0);
    check_eq({tag, "_strobe"}, {31'd0, Strobe}, 32'd1);
    check_eq({tag, "_busy"}, {31'd0, Busy}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, Done}, 32'd0);
    check_eq({tag, "_dz"}, {31'd0, DivZero}, 32'd0);
  endtask

  initial begin
    int n;
    logic [3:0] eq;
    logic [3:0] er;
    err_cnt = 0;
    chk_cnt = 0;
    Reset = 1'b1; Start = 1'b0; A = 4'd0; B = 4'd0;
    tick();
    tick();
    check_reset_vals("rst");
    Reset = 1'b0;
    tick();
    check_eq("idle_hold_busy", {31'd0, Busy}, 32'd0);

    // Directed vectors.
    run_div("d13_4", 4'd13, 4'd4, 4'd3,  4'd1, 1'b0, 4);
    run_div("d15_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 4);
    run_div("d3_5",  4'd3,  4'd5, 4'd0,  4'd3, 1'b0, 4);
    run_div("d0_7",  4'd0,  4'd7, 4'd0,  4'd0, 1'b0, 4);
    run_div("d7_0",  4'd7,  4'd0, 4'hF,  4'd7, 1'b1, 1);

    // Start and operand changes during CALC are ignored.
    A = 4'd13; B = 4'd4; Start = 1'b1;
    tick();
    A = 4'd9; B = 4'd2; Start = 1'b1;
    tick();
    A = 4'd5; B = 4'd7;
    tick();
    Start = 1'b0; A = 4'd6; B = 4'd1;
    check_eq("ign_aout_mid", {28'd0, Aout}, 32'd13);
    check_eq("ign_bout_mid", {28'd0, Bout}, 32'd4);
    wait_done("ign", n);
    check_eq("ign_q", {28'd0, Q}, 32'd3);
    check_eq("ign_r", {28'd0, R}, 32'd1);
    check_eq("ign_aout", {28'd0, Aout}, 32'd13);
    check_eq("ign_bout", {28'd0, Bout}, 32'd4);

    // Restart from DONE: old Q/R held through CALC.
    A = 4'd14; B = 4'd3; Start = 1'b1;
    tick();
    Start = 1'b0;
    check_eq("rs_strobe", {31'd0, Strobe}, 32'd1);
    check_eq("rs_q_hold", {28'd0, Q}, 32'd3);
    check_eq("rs_r_hold", {28'd0, R}, 32'd1);
    tick();
    tick();
    check_eq("rs_q_hold2", {28'd0, Q}, 32'd3);
    wait_done("rs", n);
    check_eq("rs_q", {28'd0, Q}, 32'd4);
    check_eq("rs_r", {28'd0, R}, 32'd2);

    // Start held high: one DONE cycle, then back to CALC.
    A = 4'd13; B = 4'd4; Start = 1'b1;
    tick();
    wait_done("hold", n);
    check_eq("hold_lat", n, 4);
    tick();
    check_eq("hold_done_pulse", {31'd0, Done}, 32'd0);
    check_eq("hold_rebusy", {31'd0, Busy}, 32'd1);

    // Reset on second CALC cycle with Start high.
    Start = 1'b1;
    tick();
    Reset = 1'b1;
    tick();
    check_reset_vals("midrst");
    Reset = 1'b0; Start = 1'b0;
    tick();
    check_eq("midrst_idle_busy", {31'd0, Busy}, 32'd0);
    check_eq("midrst_idle_done", {31'd0, Done}, 32'd0);

    // Exhaustive sweep including zero divisor.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          eq = 4'hF;
          er = a[3:0];
        end else begin
          eq = 4'(a / b);
          er = 4'(a % b);
        end
        run_div("sweep", a[3:0], b[3:0], eq, er, (b == 0), (b == 0) ? 1 : 4);
      end
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
